// File: rtl/hdlc_rx_drain.sv
//------------------------------------------------------------------------------
// hdlc_rx_drain
//   Drains received frames from the Hdlc RX channel into a valid/ready byte
//   stream with an end-of-frame marker. Frames flagged erroneous by RX_SC,
//   or with an illegal length, are dropped by writing Rx_Drop.
//   Optional feature macro: HDLC_RX_DRAIN_STATS_EN (adds stat_ok/stat_bad).
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hdlc_rx_drain (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx_Ready,
  output logic [2:0] Address,
  output logic       ReadEnable,
  output logic       WriteEnable,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_ok,
  output logic       frame_bad
`ifdef HDLC_RX_DRAIN_STATS_EN
  ,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_bad
`endif
);

  localparam logic [2:0] RX_SC_ADDR   = 3'h2;
  localparam logic [2:0] RX_BUFF_ADDR = 3'h3;
  localparam logic [2:0] RX_LEN_ADDR  = 3'h4;
  localparam logic [7:0] MAX_LEN      = 8'd126;
  localparam logic [7:0] DROP_CMD     = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SC   = 3'd1,
    S_LEN  = 3'd2,
    S_BYTE = 3'd3,
    S_PUSH = 3'd4,
    S_DROP = 3'd5,
    S_HOLD = 3'd6
  } state_t;

  state_t     r_state;
  logic       r_wait;   // first cycle of a read state: DataOut not yet valid
  logic [7:0] r_len;
  logic [7:0] r_cnt;

  // Length is illegal when zero or beyond the largest frame Hdlc can hold
  logic       w_len_bad;
  assign w_len_bad = (DataOut == 8'd0) || (DataOut > MAX_LEN);

  // Main drain FSM; strobes and pulses default low so each lasts one cycle
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_wait      <= 1'b0;
      r_len       <= 8'd0;
      r_cnt       <= 8'd0;
      Address     <= 3'd0;
      ReadEnable  <= 1'b0;
      WriteEnable <= 1'b0;
      DataIn      <= 8'd0;
      m_data      <= 8'd0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      frame_ok    <= 1'b0;
      frame_bad   <= 1'b0;
    end else begin
      ReadEnable  <= 1'b0;
      WriteEnable <= 1'b0;
      frame_ok    <= 1'b0;
      frame_bad   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Rx_Ready) begin
            Address    <= RX_SC_ADDR;
            ReadEnable <= 1'b1;
            r_wait     <= 1'b1;
            r_state    <= S_SC;
          end
        end
        S_SC: begin
          if (r_wait) begin
            r_wait <= 1'b0;
          end else if (|DataOut[4:2]) begin
            r_state <= S_DROP;
          end else begin
            Address    <= RX_LEN_ADDR;
            ReadEnable <= 1'b1;
            r_wait     <= 1'b1;
            r_state    <= S_LEN;
          end
        end
        S_LEN: begin
          if (r_wait) begin
            r_wait <= 1'b0;
          end else begin
            r_len <= DataOut;
            if (w_len_bad) begin
              r_state <= S_DROP;
            end else begin
              r_cnt      <= DataOut;
              Address    <= RX_BUFF_ADDR;
              ReadEnable <= 1'b1;
              r_wait     <= 1'b1;
              r_state    <= S_BYTE;
            end
          end
        end
        S_BYTE: begin
          if (r_wait) begin
            r_wait <= 1'b0;
          end else begin
            m_data  <= DataOut;
            m_valid <= 1'b1;
            m_last  <= (r_cnt == 8'd1);
            r_state <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            r_cnt   <= r_cnt - 8'd1;
            if (m_last) begin
              frame_ok <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              Address    <= RX_BUFF_ADDR;
              ReadEnable <= 1'b1;
              r_wait     <= 1'b1;
              r_state    <= S_BYTE;
            end
          end
        end
        S_DROP: begin
          Address     <= RX_SC_ADDR;
          DataIn      <= DROP_CMD;
          WriteEnable <= 1'b1;
          frame_bad   <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef HDLC_RX_DRAIN_STATS_EN
  // Saturating frame counters driven by the registered result pulses
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stat_ok  <= 16'd0;
      stat_bad <= 16'd0;
    end else begin
      if (frame_ok && (stat_ok != 16'hFFFF))
        stat_ok <= stat_ok + 16'd1;
      if (frame_bad && (stat_bad != 16'hFFFF))
        stat_bad <= stat_bad + 16'd1;
    end
  end
`endif

  // Captured length is kept for debug visibility only
  logic w_len_unused;
  assign w_len_unused = ^r_len;

endmodule

`default_nettype wire

// File: tb/tb_hdlc_rx_drain.sv
//------------------------------------------------------------------------------
// tb_hdlc_rx_drain
//   Directed bench: an Hdlc register-port model feeds frames, a scoreboard
//   derives the expected byte stream and frame outcome from each frame's
//   status/length, and one compare process checks the DUT every cycle.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hdlc_rx_drain;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Rx_Ready;
  logic [2:0] Address;
  logic       ReadEnable;
  logic       WriteEnable;
  logic [7:0] DataIn;
  logic [7:0] DataOut = 8'd0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready = 1'b1;
  logic       frame_ok;
  logic       frame_bad;
`ifdef HDLC_RX_DRAIN_STATS_EN
  logic [15:0] stat_ok;
  logic [15:0] stat_bad;
`endif

  hdlc_rx_drain dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Rx_Ready    (Rx_Ready),
    .Address     (Address),
    .ReadEnable  (ReadEnable),
    .WriteEnable (WriteEnable),
    .DataIn      (DataIn),
    .DataOut     (DataOut),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .frame_ok    (frame_ok),
    .frame_bad   (frame_bad)
`ifdef HDLC_RX_DRAIN_STATS_EN
    ,
    .stat_ok     (stat_ok),
    .stat_bad    (stat_bad)
`endif
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Hdlc register-port model ----------------
  logic [7:0] h_sc  = 8'h00;
  logic [7:0] h_len = 8'h00;
  logic [7:0] h_buf [0:255];
  int         rd_ptr   = 0;
  int         load_cnt = 0;
  int         done_cnt = 0;
  int         n_buff_reads = 0;
  int         n_writes     = 0;
  int         n_drop_bad   = 0;

  assign Rx_Ready = (load_cnt != done_cnt);

  always @(posedge Clk) begin
    if (ReadEnable) begin
      case (Address)
        3'd2: begin DataOut <= h_sc; rd_ptr <= 0; end
        3'd4: DataOut <= h_len;
        3'd3: begin
          DataOut <= h_buf[rd_ptr[7:0]];
          n_buff_reads <= n_buff_reads + 1;
          rd_ptr <= rd_ptr + 1;
          if (rd_ptr + 1 == int'(h_len)) done_cnt <= done_cnt + 1;
        end
        default: DataOut <= 8'h00;
      endcase
    end
    if (WriteEnable) begin
      n_writes <= n_writes + 1;
      if (Address == 3'd2 && DataIn == 8'h02) done_cnt <= done_cnt + 1;
      else n_drop_bad <= n_drop_bad + 1;
    end
  end

  // ---------------- consumer ready driver ----------------
  logic ready_hold = 1'b1;
  logic tog_mode   = 1'b0;
  always @(posedge Clk) begin
    #1;
    m_ready = tog_mode ? ~m_ready : ready_hold;
  end

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q [$];   // {last, data}
  logic [8:0] log_q [$];   // accepted bytes, in order
  logic [7:0] stim [0:255];
  int exp_ok = 0, exp_bad = 0;
  int n_ok = 0, n_bad = 0;

  // Frame outcome follows directly from the status byte and the length
  task automatic load_frame(input logic [7:0] sc, input logic [7:0] len);
    bit good;
    @(posedge Clk); #2;
    h_sc  = sc;
    h_len = len;
    for (int i = 0; i < 256; i++) h_buf[i] = stim[i];
    good = (sc[4:2] == 3'b000) && (len != 8'd0) && (len <= 8'd126);
    if (good) begin
      for (int i = 0; i < int'(len); i++) exp_q.push_back({(i == int'(len) - 1), stim[i]});
      exp_ok++;
    end else begin
      exp_bad++;
    end
    load_cnt++;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(n_ok == exp_ok && n_bad == exp_bad && exp_q.size() == 0) && n < 2000) begin
      @(posedge Clk); n++;
    end
    chk({name, "_done"}, (n < 2000), 1);
    repeat (3) @(posedge Clk);
  endtask

  // ---------------- compare process ----------------
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1, prev_last = 1'b0;
  logic [7:0] prev_data  = 8'd0;

  always @(negedge Clk) begin
    if (!Rst) begin
      if (ReadEnable && WriteEnable) chk("rd_wr_exclusive", 1, 0);
      if (frame_ok)  n_ok++;
      if (frame_bad) n_bad++;
      if (prev_valid && !prev_ready && !prev_rst)
        chk("stall_hold", {22'd0, m_valid, m_last, m_data}, {22'd0, 1'b1, prev_last, prev_data});
      if (m_valid && exp_q.size() == 0) begin
        chk("stray_valid", {23'd0, m_last, m_data}, 32'hFFFF_FFFF);
      end else if (m_valid && m_ready) begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("stream_byte", {23'd0, m_last, m_data}, {23'd0, e});
        log_q.push_back({m_last, m_data});
      end
    end
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_rst   = Rst;
    prev_last  = m_last;
    prev_data  = m_data;
  end

  // ---------------- directed sequence ----------------
  int base_reads, base_writes, base_log, lat;

  initial begin
    Rst = 1'b1;
    for (int i = 0; i < 256; i++) stim[i] = 8'h00;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_outputs",
        {12'd0, Address, ReadEnable, WriteEnable, DataIn, m_data, m_valid, m_last},
        32'd0);
    chk("rst_pulses", {frame_ok, frame_bad}, 0);
    @(posedge Clk); #2 Rst = 1'b0;
    repeat (2) @(posedge Clk);

    // Good 3-byte frame, consumer always ready: latency and contents
    stim[0] = 8'hAA; stim[1] = 8'h55; stim[2] = 8'h0F;
    base_reads = n_buff_reads; base_log = log_q.size();
    load_frame(8'h01, 8'd3);
    @(posedge Clk);   // edge that samples Rx_Ready
    lat = 0;
    while (!m_valid && lat < 40) begin @(posedge Clk); #1; lat++; end
    chk("first_valid_latency", lat, 6);
    wait_done("f1");
    chk("f1_b0", log_q[base_log],     {1'b0, 8'hAA});
    chk("f1_b1", log_q[base_log + 1], {1'b0, 8'h55});
    chk("f1_b2", log_q[base_log + 2], {1'b1, 8'h0F});
    chk("f1_buff_reads", n_buff_reads - base_reads, 3);
    chk("f1_ok_count", n_ok, 1);

    // Same frame, consumer ready toggling every cycle
    base_reads = n_buff_reads; base_log = log_q.size();
    tog_mode = 1'b1;
    load_frame(8'h01, 8'd3);
    wait_done("f2");
    tog_mode = 1'b0; ready_hold = 1'b1;
    chk("f2_bytes", {log_q[base_log], log_q[base_log + 1], log_q[base_log + 2]},
        {5'd0, 9'h0AA, 9'h055, 9'h10F});
    chk("f2_buff_reads", n_buff_reads - base_reads, 3);

    // Abort status: single drop write, one frame_bad, no stream
    base_writes = n_writes; base_reads = n_buff_reads;
    load_frame(8'h09, 8'd3);
    wait_done("f3");
    chk("f3_writes", n_writes - base_writes, 1);
    chk("f3_write_content_bad", n_drop_bad, 0);
    chk("f3_bad_count", n_bad, 1);
    chk("f3_no_buff_reads", n_buff_reads - base_reads, 0);

    // Illegal lengths 0 and 127 both dropped
    load_frame(8'h01, 8'd0);
    wait_done("f4");
    load_frame(8'h01, 8'd127);
    wait_done("f5");
    chk("len_bad_count", n_bad, 3);
    chk("len_bad_writes", n_writes - base_writes, 3);
    chk("len_bad_no_reads", n_buff_reads - base_reads, 0);

    // Largest legal frame goes through
    for (int i = 0; i < 126; i++) stim[i] = 8'(i * 3 + 1);
    load_frame(8'h01, 8'd126);
    wait_done("f6");
    chk("maxlen_ok_count", n_ok, 3);

    // Reset during the second byte of a 4-byte frame: re-read from the start
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
    base_log = log_q.size();
    load_frame(8'h01, 8'd4);
    lat = 0;
    while (log_q.size() == base_log && lat < 100) begin @(posedge Clk); lat++; end
    #2 ready_hold = 1'b0;
    chk("rst_first_byte_seen", (lat < 100), 1);
    lat = 0;
    while (!m_valid && lat < 40) begin @(posedge Clk); #1; lat++; end
    chk("rst_second_byte_pending", {m_valid, m_data}, {1'b1, 8'h22});
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), stim[i]});
    @(negedge Clk);
    chk("rst_mid_outputs", {m_valid, ReadEnable, WriteEnable}, 0);
    @(posedge Clk); #2 Rst = 1'b0; ready_hold = 1'b1;
    base_log = log_q.size();
    wait_done("f7");
    chk("f7_rereads_4", log_q.size() - base_log, 4);
    chk("f7_first", log_q[base_log], {1'b0, 8'h11});
    chk("f7_last",  log_q[base_log + 3], {1'b1, 8'h44});
    chk("f7_ok_count", n_ok, 4);

`ifdef HDLC_RX_DRAIN_STATS_EN
    // Counters were cleared by the mid-frame reset: only f7 follows it
    chk("stat_ok", stat_ok, 1);
    chk("stat_bad", stat_bad, 0);
    load_frame(8'h01, 8'd4);
    wait_done("f8");
    load_frame(8'h10, 8'd4);
    wait_done("f9");
    chk("stat_ok_2", stat_ok, 2);
    chk("stat_bad_1", stat_bad, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

`default_nettype wire
